int_sched: RTL

Vectored interrupt scheduler for the hardwired CPU controller. Captures up to NREQ external interrupt requests and filters them through an enable register, a global interrupt-enable flag and in-service tracking. It presents one prioritised request to the controller and hands back a vector address on acknowledge. It sits between peripheral request lines and the controller's PULSE/EI path and supports nested service of higher-priority sources.

---
 rtl/int_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/int_sched.sv
// Vectored interrupt scheduler: captures request edges, picks the highest-priority
// eligible source, and hands the controller a vector on acknowledge.
module int_sched #(
  parameter int          NREQ     = 4,
  parameter logic [7:0]  VEC_BASE = 8'hE0,
  localparam int         IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            T3,
  input  logic            CLR,
  input  logic [NREQ-1:0] IRQ,
  input  logic            LDEN,
  input  logic [NREQ-1:0] EN_IN,
  input  logic            EI_SET,
  input  logic            EI_CLR,
  input  logic            INTA,
  input  logic            IRET,
  output logic            INTR,
  output logic            VEC_VALID,
  output logic [7:0]      VECTOR,
  output logic [IDW-1:0]  ACT_ID,
  output logic [NREQ-1:0] PEND,
  output logic [NREQ-1:0] ISR,
  output logic            IE
);

  typedef enum logic [1:0] {IDLE, ASSERT, VEC} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] irq_q_reg, pend_reg, pend_next, en_reg, en_next, isr_reg, isr_next;
  logic            ie_reg, ie_next, arm_reg;
  logic            intr_reg, intr_next, vec_valid_reg, vec_valid_next;
  logic [7:0]      vector_reg, vector_next;
  logic [IDW-1:0]  act_id_reg, act_id_next;

  logic [NREQ-1:0] capture, elig, below_isr, win_onehot, iret_clr;
  logic [IDW-1:0]  win_id;
  logic            win_any, ack;

  function automatic logic [NREQ-1:0] lowest_bit(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction

  // Capture is held off for the first edge after reset so lines already high are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cap
      assign capture[gi] = arm_reg & IRQ[gi] & ~irq_q_reg[gi];
    end
  endgenerate

  // Only sources strictly above the highest-priority in-service source may nest.
  assign below_isr  = lowest_bit(isr_reg) - NREQ'(1);
  assign elig       = pend_reg & en_reg & ~isr_reg;
  assign win_onehot = lowest_bit(elig & below_isr);
  assign win_any    = |win_onehot;
  assign iret_clr   = IRET ? lowest_bit(isr_reg) : '0;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) win_id = win_id | IDW'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    ack        = 1'b0;
    case (state_reg)
      IDLE:    if (ie_reg && win_any) state_next = ASSERT;
      ASSERT: begin
        if (!ie_reg || !win_any) begin
          state_next = IDLE;
        end else if (INTA) begin
          ack        = 1'b1;
          state_next = VEC;
        end
      end
      VEC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pend_next      = (pend_reg & ~(ack ? win_onehot : '0)) | capture;
    isr_next       = (isr_reg & ~iret_clr) | (ack ? win_onehot : '0);
    en_next        = LDEN ? EN_IN : en_reg;
    ie_next        = ie_reg;
    if (ack)                 ie_next = 1'b0;
    else if (EI_CLR)         ie_next = 1'b0;
    else if (IRET || EI_SET) ie_next = 1'b1;
    act_id_next    = ack ? win_id : act_id_reg;
    vector_next    = ack ? VEC_BASE + {{(6-IDW){1'b0}}, win_id, 2'b00} : vector_reg;
    intr_next      = (state_next == ASSERT);
    vec_valid_next = (state_next == VEC);
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state_reg     <= IDLE;
      irq_q_reg     <= '0;
      pend_reg      <= '0;
      en_reg        <= '0;
      isr_reg       <= '0;
      ie_reg        <= 1'b0;
      arm_reg       <= 1'b0;
      intr_reg      <= 1'b0;
      vec_valid_reg <= 1'b0;
      vector_reg    <= '0;
      act_id_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      irq_q_reg     <= IRQ;
      pend_reg      <= pend_next;
      en_reg        <= en_next;
      isr_reg       <= isr_next;
      ie_reg        <= ie_next;
      arm_reg       <= 1'b1;
      intr_reg      <= intr_next;
      vec_valid_reg <= vec_valid_next;
      vector_reg    <= vector_next;
      act_id_reg    <= act_id_next;
    end
  end

  assign INTR      = intr_reg;
  assign VEC_VALID = vec_valid_reg;
  assign VECTOR    = vector_reg;
  assign ACT_ID    = act_id_reg;
  assign PEND      = pend_reg;
  assign ISR       = isr_reg;
  assign IE        = ie_reg;

endmodule
